// File: rtl/ex_operand_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_operand_stage_if                                                        |
// | Decode-side, later-stage writeback and EX-side signals of the operand stage|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ex_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [XLEN-1:0] id_rs1_val;
  logic [XLEN-1:0] id_rs2_val;
  logic [XLEN-1:0] id_imm;
  logic            id_use_imm;
  logic [3:0]      id_alu_ctrl;
  logic            id_inverse_set;
  logic [RA_W-1:0] id_rd;
  logic            id_wr_en;
  logic            id_is_load;
  logic            flush;
  logic [RA_W-1:0] exmem_rd;
  logic [RA_W-1:0] memwb_rd;
  logic            exmem_wr_en;
  logic            memwb_wr_en;
  logic [XLEN-1:0] exmem_result;
  logic [XLEN-1:0] memwb_result;
  logic            ex_valid;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [XLEN-1:0] ex_store_data;
  logic [3:0]      ex_alu_ctrl;
  logic            ex_inverse_set;
  logic [RA_W-1:0] ex_rd;
  logic            ex_wr_en;
  logic            ex_is_load;
  logic            stall_id;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_val, id_rs2_val, id_imm, id_use_imm,
           id_alu_ctrl, id_inverse_set, id_rd, id_wr_en, id_is_load, flush,
           exmem_rd, memwb_rd, exmem_wr_en, memwb_wr_en, exmem_result, memwb_result,
    input  ex_valid, ex_a, ex_b, ex_store_data, ex_alu_ctrl, ex_inverse_set,
           ex_rd, ex_wr_en, ex_is_load, stall_id
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_val, id_rs2_val, id_imm, id_use_imm,
           id_alu_ctrl, id_inverse_set, id_rd, id_wr_en, id_is_load, flush,
           exmem_rd, memwb_rd, exmem_wr_en, memwb_wr_en, exmem_result, memwb_result,
    output ex_valid, ex_a, ex_b, ex_store_data, ex_alu_ctrl, ex_inverse_set,
           ex_rd, ex_wr_en, ex_is_load, stall_id
  );
endinterface
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_operand_stage                                                           |
// | ID/EX register with EX/MEM + MEM/WB bypass and load-use stall detection.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ex_operand_stage_if.slave bus
);

  logic            r_valid;
  logic [RA_W-1:0] r_rs1;
  logic [RA_W-1:0] r_rs2;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;
  logic            r_use_imm;
  logic [3:0]      r_alu_ctrl;
  logic            r_inverse_set;
  logic [RA_W-1:0] r_rd;
  logic            r_wr_en;
  logic            r_is_load;

  logic            w_stall;
  logic [XLEN-1:0] w_cap_rs1_val;
  logic [XLEN-1:0] w_cap_rs2_val;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;

  function automatic logic hit(input logic en, input logic [RA_W-1:0] rd,
                               input logic [RA_W-1:0] rs);
    return en && (rd != '0) && (rd == rs);
  endfunction

  assign w_stall = r_valid && r_is_load && r_wr_en && bus.id_valid && (r_rd != '0) &&
                   ((bus.id_rs1 == r_rd) || (!bus.id_use_imm && (bus.id_rs2 == r_rd))) &&
                   !bus.flush;

  // A register-file write landing in the capture cycle is not yet visible on the read port.
  assign w_cap_rs1_val = hit(bus.memwb_wr_en, bus.memwb_rd, bus.id_rs1) ? bus.memwb_result
                                                                        : bus.id_rs1_val;
  assign w_cap_rs2_val = hit(bus.memwb_wr_en, bus.memwb_rd, bus.id_rs2) ? bus.memwb_result
                                                                        : bus.id_rs2_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.flush || w_stall) begin
      r_valid       <= 1'b0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rs1_val     <= '0;
      r_rs2_val     <= '0;
      r_imm         <= '0;
      r_use_imm     <= 1'b0;
      r_alu_ctrl    <= 4'd0;
      r_inverse_set <= 1'b0;
      r_rd          <= '0;
      r_wr_en       <= 1'b0;
      r_is_load     <= 1'b0;
    end else begin
      r_valid       <= bus.id_valid;
      r_rs1         <= bus.id_rs1;
      r_rs2         <= bus.id_rs2;
      r_rs1_val     <= w_cap_rs1_val;
      r_rs2_val     <= w_cap_rs2_val;
      r_imm         <= bus.id_imm;
      r_use_imm     <= bus.id_use_imm;
      r_alu_ctrl    <= bus.id_alu_ctrl;
      r_inverse_set <= bus.id_inverse_set;
      r_rd          <= bus.id_rd;
      r_wr_en       <= bus.id_wr_en && bus.id_valid;
      r_is_load     <= bus.id_is_load && bus.id_valid;
    end
  end

  generate
    if (FWD_EN != 0) begin : g_fwd
      always_comb begin
        w_src1 = r_rs1_val;
        if (r_rs1 == '0)
          w_src1 = '0;
        else if (hit(bus.exmem_wr_en, bus.exmem_rd, r_rs1))
          w_src1 = bus.exmem_result;
        else if (hit(bus.memwb_wr_en, bus.memwb_rd, r_rs1))
          w_src1 = bus.memwb_result;
      end
      always_comb begin
        w_src2 = r_rs2_val;
        if (r_rs2 == '0)
          w_src2 = '0;
        else if (hit(bus.exmem_wr_en, bus.exmem_rd, r_rs2))
          w_src2 = bus.exmem_result;
        else if (hit(bus.memwb_wr_en, bus.memwb_rd, r_rs2))
          w_src2 = bus.memwb_result;
      end
    end else begin : g_no_fwd
      assign w_src1 = (r_rs1 == '0) ? '0 : r_rs1_val;
      assign w_src2 = (r_rs2 == '0) ? '0 : r_rs2_val;
    end
  endgenerate

  assign bus.ex_valid       = r_valid;
  assign bus.ex_a           = r_valid ? w_src1 : '0;
  assign bus.ex_b           = !r_valid ? '0 : (r_use_imm ? r_imm : w_src2);
  assign bus.ex_store_data  = r_valid ? w_src2 : '0;
  assign bus.ex_alu_ctrl    = r_alu_ctrl;
  assign bus.ex_inverse_set = r_inverse_set;
  assign bus.ex_rd          = r_rd;
  assign bus.ex_wr_en       = r_valid && r_wr_en;
  assign bus.ex_is_load     = r_valid && r_is_load;
  assign bus.stall_id       = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ex_operand_stage                                                        |
// | Directed vector table plus hand sequences for stall, flush and reset.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ex_operand_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_operand_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

  ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [31:0] rs1v;
    logic [4:0]  rs2;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic        use_imm;
    logic [3:0]  alu;
    logic        inv;
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
    logic        cwb_en;
    logic [4:0]  cwb_rd;
    logic [31:0] cwb_res;
    logic        xm_en;
    logic [4:0]  xm_rd;
    logic [31:0] xm_res;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic        e_valid;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [31:0] e_sd;
    logic [3:0]  e_alu;
    logic        e_inv;
    logic [4:0]  e_rd;
    logic        e_wr;
    logic        e_ld;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;
  vec_t vecs[12];

  function automatic vec_t mk(input logic [4:0] rs1, input logic [31:0] rs1v,
                              input logic [4:0] rs2, input logic [31:0] rs2v,
                              input logic [3:0] alu, input logic [4:0] rd);
    vec_t v = '0;
    v.valid = 1'b1; v.rs1 = rs1; v.rs1v = rs1v; v.rs2 = rs2; v.rs2v = rs2v;
    v.alu = alu; v.rd = rd; v.wr = 1'b1;
    v.e_valid = 1'b1; v.e_a = rs1v; v.e_b = rs2v; v.e_sd = rs2v;
    v.e_alu = alu; v.e_rd = rd; v.e_wr = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_late(input logic xe, input logic [4:0] xr, input logic [31:0] xv,
                          input logic we, input logic [4:0] wr, input logic [31:0] wv);
    bus.exmem_wr_en = xe; bus.exmem_rd = xr; bus.exmem_result = xv;
    bus.memwb_wr_en = we; bus.memwb_rd = wr; bus.memwb_result = wv;
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_val = '0;
    bus.id_rs2_val = '0; bus.id_imm = '0; bus.id_use_imm = 1'b0; bus.id_alu_ctrl = 4'd0;
    bus.id_inverse_set = 1'b0; bus.id_rd = '0; bus.id_wr_en = 1'b0; bus.id_is_load = 1'b0;
    bus.flush = 1'b0;
    set_late(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic drive_id(input vec_t v);
    bus.id_valid = v.valid; bus.id_rs1 = v.rs1; bus.id_rs2 = v.rs2;
    bus.id_rs1_val = v.rs1v; bus.id_rs2_val = v.rs2v; bus.id_imm = v.imm;
    bus.id_use_imm = v.use_imm; bus.id_alu_ctrl = v.alu; bus.id_inverse_set = v.inv;
    bus.id_rd = v.rd; bus.id_wr_en = v.wr; bus.id_is_load = v.ld;
  endtask

  task automatic check_ex(input vec_t v, input string n);
    chk({n, ".ex_valid"}, 32'(bus.ex_valid), 32'(v.e_valid));
    chk({n, ".ex_a"}, bus.ex_a, v.e_a);
    chk({n, ".ex_b"}, bus.ex_b, v.e_b);
    chk({n, ".ex_store_data"}, bus.ex_store_data, v.e_sd);
    chk({n, ".ex_alu_ctrl"}, 32'(bus.ex_alu_ctrl), 32'(v.e_alu));
    chk({n, ".ex_inverse_set"}, 32'(bus.ex_inverse_set), 32'(v.e_inv));
    chk({n, ".ex_rd"}, 32'(bus.ex_rd), 32'(v.e_rd));
    chk({n, ".ex_wr_en"}, 32'(bus.ex_wr_en), 32'(v.e_wr));
    chk({n, ".ex_is_load"}, 32'(bus.ex_is_load), 32'(v.e_ld));
  endtask

  task automatic check_zero(input string n);
    chk({n, ".ex_valid"}, 32'(bus.ex_valid), 32'd0);
    chk({n, ".ex_a"}, bus.ex_a, 32'd0);
    chk({n, ".ex_b"}, bus.ex_b, 32'd0);
    chk({n, ".ex_store_data"}, bus.ex_store_data, 32'd0);
    chk({n, ".ex_alu_ctrl"}, 32'(bus.ex_alu_ctrl), 32'd0);
    chk({n, ".ex_inverse_set"}, 32'(bus.ex_inverse_set), 32'd0);
    chk({n, ".ex_rd"}, 32'(bus.ex_rd), 32'd0);
    chk({n, ".ex_wr_en"}, 32'(bus.ex_wr_en), 32'd0);
    chk({n, ".ex_is_load"}, 32'(bus.ex_is_load), 32'd0);
    chk({n, ".stall_id"}, 32'(bus.stall_id), 32'd0);
  endtask

  task automatic load_into_ex();
    vec_t v;
    v = mk(5'd1, 32'd0, 5'd0, 32'd0, 4'b0100, 5'd5);
    v.ld = 1'b1; v.use_imm = 1'b1; v.imm = 32'h4;
    @(negedge clk);
    idle();
    drive_id(v);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sub_r5();
    idle();
    bus.id_valid = 1'b1; bus.id_rs1 = 5'd2; bus.id_rs1_val = 32'h20;
    bus.id_rs2 = 5'd5; bus.id_rs2_val = 32'h0; bus.id_alu_ctrl = 4'b0101;
    bus.id_rd = 5'd6; bus.id_wr_en = 1'b1;
  endtask

  initial begin
    vecs[0] = mk(5'd1, 32'hFFFFFFFF, 5'd2, 32'h0, 4'b0100, 5'd3);
    vecs[1] = mk(5'd3, 32'h11111111, 5'd4, 32'h22222222, 4'b0100, 5'd8);
    vecs[1].xm_en = 1'b1; vecs[1].xm_rd = 5'd3; vecs[1].xm_res = 32'hF0F0F0F0;
    vecs[1].wb_en = 1'b1; vecs[1].wb_rd = 5'd3; vecs[1].wb_res = 32'h12345678;
    vecs[1].e_a = 32'hF0F0F0F0;
    vecs[2] = vecs[1]; vecs[2].xm_en = 1'b0; vecs[2].e_a = 32'h12345678;
    vecs[3] = mk(5'd0, 32'h55555555, 5'd6, 32'h6, 4'b0100, 5'd9);
    vecs[3].xm_en = 1'b1; vecs[3].xm_rd = 5'd0; vecs[3].xm_res = 32'hDEADBEEF;
    vecs[3].e_a = 32'h0;
    vecs[4] = mk(5'd7, 32'h0, 5'd8, 32'h8, 4'b0100, 5'd10);
    vecs[4].cwb_en = 1'b1; vecs[4].cwb_rd = 5'd7; vecs[4].cwb_res = 32'h42;
    vecs[4].e_a = 32'h42;
    vecs[5] = mk(5'd9, 32'h9, 5'd10, 32'hA, 4'b1100, 5'd11);
    vecs[5].use_imm = 1'b1; vecs[5].imm = 32'hFFFFFFFF; vecs[5].inv = 1'b1;
    vecs[5].e_b = 32'hFFFFFFFF; vecs[5].e_inv = 1'b1;
    vecs[6] = mk(5'd12, 32'h12345, 5'd13, 32'h6789, 4'b0101, 5'd14);
    vecs[6].valid = 1'b0; vecs[6].ld = 1'b1;
    vecs[6].e_valid = 1'b0; vecs[6].e_a = 32'h0; vecs[6].e_b = 32'h0;
    vecs[6].e_sd = 32'h0; vecs[6].e_wr = 1'b0;
    vecs[7] = mk(5'd1, 32'h100, 5'd0, 32'h0, 4'b0100, 5'd5);
    vecs[7].ld = 1'b1; vecs[7].use_imm = 1'b1; vecs[7].imm = 32'h8;
    vecs[7].e_b = 32'h8; vecs[7].e_ld = 1'b1;
    vecs[8] = mk(5'd1, 32'h1, 5'd11, 32'h0, 4'b1001, 5'd15);
    vecs[8].wb_en = 1'b1; vecs[8].wb_rd = 5'd11; vecs[8].wb_res = 32'h77;
    vecs[8].xm_en = 1'b1; vecs[8].xm_rd = 5'd12; vecs[8].xm_res = 32'h99;
    vecs[8].e_b = 32'h77; vecs[8].e_sd = 32'h77;
    vecs[9] = mk(5'd2, 32'h2, 5'd0, 32'h33, 4'b1000, 5'd16);
    vecs[9].wb_en = 1'b1; vecs[9].wb_rd = 5'd0; vecs[9].wb_res = 32'h44;
    vecs[9].e_b = 32'h0; vecs[9].e_sd = 32'h0;
    vecs[10] = mk(5'd13, 32'h0, 5'd14, 32'h14, 4'b0100, 5'd17);
    vecs[10].cwb_en = 1'b1; vecs[10].cwb_rd = 5'd13; vecs[10].cwb_res = 32'hAA;
    vecs[10].xm_en = 1'b1; vecs[10].xm_rd = 5'd13; vecs[10].xm_res = 32'hBB;
    vecs[10].e_a = 32'hBB;
    vecs[11] = mk(5'd15, 32'h0F, 5'd16, 32'h10, 4'b0010, 5'd18);
    vecs[11].xm_rd = 5'd15; vecs[11].xm_res = 32'h1;
    vecs[11].wb_rd = 5'd16; vecs[11].wb_res = 32'h2;

    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while a valid instruction sits in EX
    @(negedge clk);
    drive_id(vecs[0]);
    @(posedge clk);
    #1 idle();
    #1 chk("pre_reset.ex_valid", 32'(bus.ex_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      idle();
      drive_id(vecs[i]);
      set_late(1'b0, 5'd0, 32'd0, vecs[i].cwb_en, vecs[i].cwb_rd, vecs[i].cwb_res);
      @(posedge clk);
      #1 idle();
      set_late(vecs[i].xm_en, vecs[i].xm_rd, vecs[i].xm_res,
               vecs[i].wb_en, vecs[i].wb_rd, vecs[i].wb_res);
      #1 check_ex(vecs[i], $sformatf("v%0d", i));
    end

    // Load-use stall, use_imm exemption, then bubble and write-through capture
    load_into_ex();
    drive_sub_r5();
    #1 chk("lu.stall", 32'(bus.stall_id), 32'd1);
    bus.id_use_imm = 1'b1; bus.id_imm = 32'h3;
    #1 chk("lu.stall_use_imm", 32'(bus.stall_id), 32'd0);
    bus.id_use_imm = 1'b0;
    #1 chk("lu.stall_again", 32'(bus.stall_id), 32'd1);
    @(posedge clk);
    #1 chk("lu.bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu.bubble_wr_en", 32'(bus.ex_wr_en), 32'd0);
    chk("lu.stall_released", 32'(bus.stall_id), 32'd0);
    set_late(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000000A);
    @(posedge clk);
    #1 idle();
    #1 chk("lu.ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu.ex_a", bus.ex_a, 32'h20);
    chk("lu.ex_b", bus.ex_b, 32'h0000000A);
    chk("lu.ex_alu_ctrl", 32'(bus.ex_alu_ctrl), 32'b0101);

    // Flush takes priority over stall
    load_into_ex();
    drive_sub_r5();
    #1 chk("fl.stall_noflush", 32'(bus.stall_id), 32'd1);
    bus.flush = 1'b1;
    #1 chk("fl.stall", 32'(bus.stall_id), 32'd0);
    @(posedge clk);
    #1 idle();
    #1 chk("fl.ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("fl.ex_wr_en", 32'(bus.ex_wr_en), 32'd0);
    chk("fl.ex_a", bus.ex_a, 32'h0);

    // Reset during a stall drops the bubble; next edge captures normally
    load_into_ex();
    drive_sub_r5();
    bus.id_rs2_val = 32'h77;
    #1 chk("rs.stall", 32'(bus.stall_id), 32'd1);
    rst_n = 1'b0;
    #1 chk("rs.stall_in_reset", 32'(bus.stall_id), 32'd0);
    chk("rs.valid_in_reset", 32'(bus.ex_valid), 32'd0);
    rst_n = 1'b1;
    #1 chk("rs.stall_after", 32'(bus.stall_id), 32'd0);
    @(posedge clk);
    #1 idle();
    #1 chk("rs.ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("rs.ex_b", bus.ex_b, 32'h77);
    chk("rs.ex_alu_ctrl", 32'(bus.ex_alu_ctrl), 32'b0101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
